// File: rtl/seven_seg_scanner_if.sv
// Bus between the value source (master) and the seven-segment scanner (slave).
// load is a capture strobe with no back-pressure: the slave takes value/dp_in/blank_in on every edge load is high.
interface seven_seg_scanner_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     blank_in;
    logic                  lzb_en;
    logic [6:0]            seg_out;
    logic                  dp_out;
    logic [DIGITS-1:0]     an_out;
    logic                  frame_tick;

    modport master (
        output load, value, dp_in, blank_in, lzb_en,
        input  seg_out, dp_out, an_out, frame_tick
    );

    modport slave (
        input  load, value, dp_in, blank_in, lzb_en,
        output seg_out, dp_out, an_out, frame_tick
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver with shadow/display
// double buffering, so a new value only appears at a frame boundary.
module seven_seg_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2,
    parameter int HEX_EN      = 1
) (
    input logic               clk,
    input logic               rst,
    seven_seg_scanner_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   sh_val, dv_val;
    logic [DIGITS-1:0]     sh_dp, sh_blank, dv_dp, dv_blank;
    logic                  pending;
    logic                  updated;
    logic                  slot_end, frame_end;

    assign slot_end  = (cnt == CW'(REFRESH_DIV - 1));
    assign frame_end = slot_end && (idx == IW'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= '0;
            sh_val   <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            dv_val   <= '0;
            dv_dp    <= '0;
            dv_blank <= '0;
            pending  <= 1'b0;
            updated  <= 1'b0;
        end else begin
            cnt     <= slot_end ? '0 : cnt + CW'(1);
            updated <= frame_end && pending;
            if (slot_end) begin
                idx <= frame_end ? '0 : idx + IW'(1);
            end
            // Transfer uses the pre-edge shadow; a coincident load re-arms pending below.
            if (frame_end && pending) begin
                dv_val   <= sh_val;
                dv_dp    <= sh_dp;
                dv_blank <= sh_blank;
                pending  <= 1'b0;
            end
            if (bus.load) begin
                sh_val   <= bus.value;
                sh_dp    <= bus.dp_in;
                sh_blank <= bus.blank_in;
                pending  <= 1'b1;
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0:    glyph = 7'b1111110;
            4'h1:    glyph = 7'b0110000;
            4'h2:    glyph = 7'b1101101;
            4'h3:    glyph = 7'b1111001;
            4'h4:    glyph = 7'b0110011;
            4'h5:    glyph = 7'b1011011;
            4'h6:    glyph = 7'b1011111;
            4'h7:    glyph = 7'b1110000;
            4'h8:    glyph = 7'b1111111;
            4'h9:    glyph = 7'b1111011;
            4'hA:    glyph = 7'b1110111;
            4'hB:    glyph = 7'b0011111;
            4'hC:    glyph = 7'b1001110;
            4'hD:    glyph = 7'b0111101;
            4'hE:    glyph = 7'b1001111;
            default: glyph = 7'b1000111;
        endcase
    endfunction

    logic [DIGITS-1:0] zero_from;
    logic              run;
    logic [3:0]        nib;
    logic              cur_dp, cur_blank, cur_zero;
    logic              active, dark;
    logic [6:0]        seg_n;
    logic              dp_n;
    logic [DIGITS-1:0] an_n;

    // zero_from[i]: nibble i and every nibble above it are zero.
    always_comb begin
        run       = 1'b1;
        zero_from = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run          = run && (dv_val[4*i +: 4] == 4'd0);
            zero_from[i] = run;
        end
    end

    always_comb begin
        nib       = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_zero  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = dv_val[4*i +: 4];
                cur_dp    = dv_dp[i];
                cur_blank = dv_blank[i];
                cur_zero  = zero_from[i];
            end
        end
        active = (cnt >= CW'(GUARD));
        dark   = cur_blank
              || ((HEX_EN == 0) && (nib >= 4'd10))
              || (bus.lzb_en && (idx != '0) && cur_zero);
        for (int i = 0; i < DIGITS; i++) begin
            an_n[i] = !(active && (idx == IW'(i)));
        end
        seg_n = (active && !dark) ? ~glyph(nib) : 7'h7F;
        dp_n  = !(active && !dark && cur_dp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.an_out     <= '1;
            bus.seg_out    <= 7'h7F;
            bus.dp_out     <= 1'b1;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.an_out     <= an_n;
            bus.seg_out    <= seg_n;
            bus.dp_out     <= dp_n;
            bus.frame_tick <= updated;
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: two instances (HEX_EN=1 and HEX_EN=0)
// share stimulus; expected digit images are queued and checked at each slot activation.
module tb_seven_seg_scanner;
    localparam int DIGITS = 4;
    localparam int RD     = 8;
    localparam int GUARD  = 2;
    localparam int W      = 20;

    localparam logic [6:0] G0 = 7'h01, G1 = 7'h4F, G2 = 7'h12, G3 = 7'h06;
    localparam logic [6:0] G4 = 7'h4C, G5 = 7'h24, GA = 7'h08, BL = 7'h7F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        lzb_en = 1'b0;

    always #5 clk = ~clk;

    seven_seg_scanner_if #(.DIGITS(DIGITS)) bus ();
    seven_seg_scanner_if #(.DIGITS(DIGITS)) bus0 ();

    assign bus.load      = load;
    assign bus.value     = value;
    assign bus.dp_in     = dp_in;
    assign bus.blank_in  = blank_in;
    assign bus.lzb_en    = lzb_en;
    assign bus0.load     = load;
    assign bus0.value    = value;
    assign bus0.dp_in    = dp_in;
    assign bus0.blank_in = blank_in;
    assign bus0.lzb_en   = lzb_en;

    seven_seg_scanner #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .GUARD(GUARD), .HEX_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    seven_seg_scanner #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .GUARD(GUARD), .HEX_EN(0)) dut_nohex (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int tick_cnt = 0;
    logic [W-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Entry: {an, seg/dp of HEX_EN=1 instance, seg/dp of HEX_EN=0 instance}.
    task automatic push(input logic [3:0] an, input logic [6:0] sh, input logic dh,
                        input logic [6:0] sn, input logic dn);
        exp_q.push_back({an, sh, dh, sn, dn});
    endtask

    task automatic push4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        push(4'b1110, s0, 1'b1, s0, 1'b1);
        push(4'b1101, s1, 1'b1, s1, 1'b1);
        push(4'b1011, s2, 1'b1, s2, 1'b1);
        push(4'b0111, s3, 1'b1, s3, 1'b1);
    endtask

    // Monitor: pops one expectation each time a digit slot turns its anode on.
    logic         prev_act = 1'b0;
    logic         prev_ft = 1'b0;
    int           idle_run = 0;
    logic [W-1:0] e;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_ft) check("frame_tick_width", 32'(bus.frame_tick), 0);
            if (bus.an_out != 4'hF && !prev_act && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("an_hex", 32'(bus.an_out), 32'(e[19:16]));
                check("seg_dp_hex", 32'({bus.seg_out, bus.dp_out}), 32'(e[15:8]));
                check("an_nohex", 32'(bus0.an_out), 32'(e[19:16]));
                check("seg_dp_nohex", 32'({bus0.seg_out, bus0.dp_out}), 32'(e[7:0]));
                check("guard_len", 32'(idle_run), GUARD);
            end
            if (bus.frame_tick) tick_cnt++;
        end
        prev_act = (bus.an_out != 4'hF);
        prev_ft  = bus.frame_tick;
        idle_run = prev_act ? 0 : idle_run + 1;
    end

    task automatic drive_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        value    = v;
        dp_in    = dp;
        blank_in = bl;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_tick(output int at);
        int b;
        b = 0;
        @(negedge clk);
        while (!bus.frame_tick && b < 80) begin
            @(negedge clk);
            b++;
        end
        check("tick_seen", 32'(bus.frame_tick), 1);
        at = cyc;
    endtask

    // Returns in guard cycle 1 of slot 0, found by waiting for digit 3 to end.
    task automatic sync_scan();
        int b;
        b = 0;
        while (bus.an_out != 4'b0111 && b < 80) begin
            @(negedge clk);
            b++;
        end
        b = 0;
        while (bus.an_out != 4'hF && b < 10) begin
            @(negedge clk);
            b++;
        end
        check("sync_scan", 32'(bus.an_out), 'hF);
    endtask

    task automatic wait_empty();
        int b;
        b = 0;
        while (exp_q.size() > 0 && b < 100) begin
            @(negedge clk);
            b++;
        end
        check("queue_drain", 32'(exp_q.size()), 0);
    endtask

    int t0, t1, t2, k;

    initial begin
        repeat (4) @(negedge clk);
        check("rst_an", 32'(bus.an_out), 'hF);
        check("rst_seg", 32'(bus.seg_out), 'h7F);
        check("rst_dp", 32'(bus.dp_out), 1);
        check("rst_tick", 32'(bus.frame_tick), 0);
        rst = 1'b0;

        // Cleared display shows zeros on every digit.
        sync_scan();
        push4(G0, G0, G0, G0);
        wait_empty();

        drive_load(16'h1234, 4'b0000, 4'b0000);
        wait_tick(t0);
        push4(G4, G3, G2, G1);
        wait_empty();

        // Leading-zero blanking and hex glyphs; HEX_EN=0 blanks the A.
        lzb_en = 1'b1;
        drive_load(16'h00A5, 4'b0000, 4'b0000);
        wait_tick(t0);
        push(4'b1110, G5, 1'b1, G5, 1'b1);
        push(4'b1101, GA, 1'b1, BL, 1'b1);
        push(4'b1011, BL, 1'b1, BL, 1'b1);
        push(4'b0111, BL, 1'b1, BL, 1'b1);
        wait_empty();
        lzb_en = 1'b0;

        // Mid-frame loads must not tear the frame; last load wins.
        drive_load(16'h1111, 4'b0000, 4'b0000);
        wait_tick(t0);
        push4(G1, G1, G1, G1);
        repeat (15) @(negedge clk);
        drive_load(16'h2222, 4'b0000, 4'b0000);
        repeat (4) @(negedge clk);
        drive_load(16'h3333, 4'b0000, 4'b0000);
        wait_empty();
        wait_tick(t1);
        check("tick_period_a", 32'(t1 - t0), 32);
        push4(G3, G3, G3, G3);
        wait_empty();

        // Load on the frame-boundary edge: older shadow shows first.
        drive_load(16'h5555, 4'b0000, 4'b0000);
        wait_tick(t0);
        push4(G5, G5, G5, G5);
        repeat (5) @(negedge clk);
        drive_load(16'h2222, 4'b0000, 4'b0000);
        repeat (24) @(negedge clk);
        drive_load(16'h1111, 4'b0000, 4'b0000);
        wait_tick(t1);
        check("tick_period_b", 32'(t1 - t0), 32);
        push4(G2, G2, G2, G2);
        wait_tick(t2);
        check("tick_period_c", 32'(t2 - t1), 32);
        push4(G1, G1, G1, G1);
        wait_empty();

        // Decimal point on digit 2, force-blank on digit 0.
        drive_load(16'h1234, 4'b0100, 4'b0001);
        wait_tick(t0);
        push(4'b1110, BL, 1'b1, BL, 1'b1);
        push(4'b1101, G3, 1'b1, G3, 1'b1);
        push(4'b1011, G2, 1'b0, G2, 1'b0);
        push(4'b0111, G1, 1'b1, G1, 1'b1);
        wait_empty();

        // Reset mid-slot with a pending load: everything dark, pending dropped.
        drive_load(16'h5555, 4'b0000, 4'b0000);
        wait_tick(t0);
        push4(G5, G5, G5, G5);
        wait_empty();
        repeat (10) @(negedge clk);
        drive_load(16'h1111, 4'b0000, 4'b0000);
        check("pre_rst_active", 32'(bus.an_out), 'hE);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_an", 32'(bus.an_out), 'hF);
        check("midrst_seg", 32'(bus.seg_out), 'h7F);
        check("midrst_dp", 32'(bus.dp_out), 1);
        check("midrst_tick", 32'(bus.frame_tick), 0);
        rst = 1'b0;
        k = tick_cnt;
        sync_scan();
        push4(G0, G0, G0, G0);
        wait_empty();
        check("no_tick_after_rst", 32'(tick_cnt), 32'(k));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
